// File: rtl/sync_fifo_stream_adapter.sv
// rtl/sync_fifo_stream_adapter.sv - FWFT valid/ready stream stage behind a fixed-latency sync FIFO read port.
// Optional occupancy port enabled by macro FIFO_STREAM_OCC_EN.
module sync_fifo_stream_adapter #(
    parameter int DW        = 18,
    parameter int RD_LAT    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_empty,
    output logic          fifo_ren,
    input  logic          fifo_dout_valid,
    input  logic [DW-1:0] fifo_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          err_unexp
`ifdef FIFO_STREAM_OCC_EN
    ,
    output logic [$clog2(BUF_DEPTH):0] occ
`endif
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    // At most one read issues per cycle and each lands RD_LAT cycles later.
    localparam int IW = $clog2(RD_LAT + 1);

    logic [DW-1:0] mem [BUF_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
    logic [CW-1:0] count, count_n, credit;
    logic [IW-1:0] inflight, inflight_n;
    logic [DW-1:0] head;
    logic          pop, push, full, push_acc;

    assign pop      = m_valid & m_ready;
    assign push     = fifo_dout_valid;
    assign full     = (count == CW'(BUF_DEPTH));
    assign push_acc = push & ~full;
    assign credit   = count + CW'(inflight);
    assign m_valid  = (count != '0);

    // Gated by rst_n so no read escapes while the FIFO is being reset alongside us.
    assign fifo_ren = rst_n & ~fifo_empty & ((credit - CW'(pop)) < CW'(BUF_DEPTH));

    always_comb begin
        inflight_n = inflight;
        if (fifo_ren && !push) begin
            inflight_n = inflight + IW'(1);
        end else if (!fifo_ren && push && inflight != '0) begin
            inflight_n = inflight - IW'(1);
        end
    end

    always_comb begin
        count_n  = count + CW'(push_acc) - CW'(pop);
        rd_ptr_n = rd_ptr + AW'(pop);
        // Next head word is the incoming one only when the buffer is empty after the pop.
        if (push_acc && (wr_ptr == rd_ptr_n)) begin
            head = fifo_dout;
        end else begin
            head = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            inflight  <= '0;
            m_data    <= '0;
            err_unexp <= 1'b0;
        end else begin
            count    <= count_n;
            inflight <= inflight_n;
            rd_ptr   <= rd_ptr_n;
            if (push_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (count_n != '0) begin
                m_data <= head;
            end
            if (push && (inflight == '0 || full)) begin
                err_unexp <= 1'b1;
            end
        end
    end

`ifdef FIFO_STREAM_OCC_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ <= '0;
        end else begin
            occ <= credit;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_stream_adapter.sv
// tb/tb_sync_fifo_stream_adapter.sv - self-checking bench for sync_fifo_stream_adapter with a queue-based FIFO and scoreboard.
module tb_sync_fifo_stream_adapter;

    localparam int DW     = 18;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, fifo_empty, fifo_ren, fifo_dout_valid;
    logic          m_valid, m_ready, err_unexp;
    logic [DW-1:0] fifo_dout, m_data;
`ifdef FIFO_STREAM_OCC_EN
    logic [2:0]    occ;
`endif

    sync_fifo_stream_adapter #(.DW(DW), .RD_LAT(RD_LAT), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fifo_empty(fifo_empty),
        .fifo_ren(fifo_ren),
        .fifo_dout_valid(fifo_dout_valid),
        .fifo_dout(fifo_dout),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .err_unexp(err_unexp)
`ifdef FIFO_STREAM_OCC_EN
        ,
        .occ(occ)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] src[$];
    logic [DW-1:0] exp_q[$];
    bit            pv[RD_LAT];
    logic [DW-1:0] pd[RD_LAT];
    int            landed, reads, consumed, cyc, first_ren, first_val, gaps, prev_sz;
    int            rel_cyc, t0, pushed;
    bit            chk, gap_en;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample between edges, then advance the FIFO model and scoreboard.
    task automatic cycle();
        bit v_exp, ren_s, pop_s, ren_exp;
        int sz;
        #4;
        sz    = exp_q.size();
        v_exp = (landed > 0);
        pop_s = v_exp && m_ready;
        if (chk) begin
            check("m_valid", 32'(m_valid), 32'(v_exp));
            if (v_exp && sz > 0) check("m_data", 32'(m_data), 32'(exp_q[0]));
            ren_exp = !fifo_empty && ((sz - int'(pop_s)) < DEPTH);
            check("fifo_ren", 32'(fifo_ren), 32'(ren_exp));
            check("err_idle", 32'(err_unexp), 32'(0));
`ifdef FIFO_STREAM_OCC_EN
            check("occ", 32'(occ), 32'(prev_sz));
`endif
        end
        ren_s = fifo_ren;
        if (ren_s && first_ren < 0) first_ren = cyc;
        if (m_valid && first_val < 0) first_val = cyc;
        if (gap_en && first_val >= 0 && consumed < 16 && !m_valid) gaps++;
        prev_sz = sz;
        @(posedge clk);
        #1;
        cyc++;
        if (pop_s) begin
            void'(exp_q.pop_front());
            landed--;
            consumed++;
        end
        if (fifo_dout_valid) landed++;
        for (int i = RD_LAT - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = ren_s && (src.size() > 0);
        pd[0] = '0;
        if (pv[0]) begin
            pd[0] = src.pop_front();
            exp_q.push_back(pd[0]);
            reads++;
        end
        fifo_dout_valid = pv[RD_LAT-1];
        fifo_dout       = pd[RD_LAT-1];
        fifo_empty      = (src.size() == 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        chk   = 1'b0;
        gap_en = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        src.delete();
        for (int i = 0; i < RD_LAT; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        landed = 0;
        fifo_dout_valid = 1'b0;
        fifo_dout = '0;
        fifo_empty = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic release_reset();
        fifo_empty = (src.size() == 0);
        #1;
        check("rst_ren", 32'(fifo_ren), 32'(0));
        check("rst_valid", 32'(m_valid), 32'(0));
        check("rst_err", 32'(err_unexp), 32'(0));
        check("rst_data", 32'(m_data), 32'(0));
        rst_n = 1'b1;
        chk = 1'b1;
        reads = 0;
        consumed = 0;
        first_ren = -1;
        first_val = -1;
        gaps = 0;
        rel_cyc = cyc;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc = 0;
        prev_sz = 0;

        // Reset behaviour and streaming of 1..16 with continuous m_ready.
        do_reset();
        for (int i = 1; i <= 16; i++) src.push_back(DW'(i));
        release_reset();
        m_ready = 1'b1;
        gap_en = 1'b1;
        for (int k = 0; k < 60 && consumed < 16; k++) cycle();
        gap_en = 1'b0;
        check("stream_count", 32'(consumed), 32'(16));
        check("stream_first_ren", 32'(first_ren), 32'(rel_cyc));
        check("stream_latency", 32'(first_val - first_ren), 32'(RD_LAT + 1));
        check("stream_gaps", 32'(gaps), 32'(0));

        // Back-pressure: credits cap reads at DEPTH, a single pop frees one.
        do_reset();
        for (int i = 0; i < 16; i++) src.push_back(DW'($urandom));
        release_reset();
        repeat (10) cycle();
        check("bp_reads", 32'(reads), 32'(DEPTH));
        check("bp_ren_low", 32'(fifo_ren), 32'(0));
`ifdef FIFO_STREAM_OCC_EN
        check("bp_occ", 32'(occ), 32'(DEPTH));
`endif
        m_ready = 1'b1;
        cycle();
        m_ready = 1'b0;
        repeat (8) cycle();
        check("bp_pulse_reads", 32'(reads), 32'(DEPTH + 1));
        check("bp_pulse_pop", 32'(consumed), 32'(1));
        for (int k = 0; k < 200 && consumed < 16; k++) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        check("bp_drain", 32'(consumed), 32'(16));

        // Empty then refill.
        do_reset();
        for (int i = 1; i <= 3; i++) src.push_back(DW'(i));
        release_reset();
        m_ready = 1'b1;
        repeat (12) cycle();
        check("empty_consumed", 32'(consumed), 32'(3));
        check("empty_valid", 32'(m_valid), 32'(0));
        check("empty_ren", 32'(fifo_ren), 32'(0));
        first_val = -1;
        src.push_back(DW'(4));
        fifo_empty = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 10 && first_val < 0; k++) cycle();
        check("refill_latency", 32'(first_val - t0), 32'(RD_LAT + 1));
        repeat (3) cycle();
        check("refill_consumed", 32'(consumed), 32'(4));

        // Randomized traffic: bursty refill and varying consumer pressure.
        do_reset();
        release_reset();
        pushed = 0;
        for (int k = 0; k < 600; k++) begin
            if (pushed < 300 && $urandom_range(0, 2) != 0) begin
                src.push_back(DW'($urandom));
                pushed++;
            end
            fifo_empty = (src.size() == 0);
            if (k < 300) m_ready = ($urandom_range(0, 3) != 0);
            else         m_ready = ($urandom_range(0, 3) == 0);
            cycle();
        end
        m_ready = 1'b1;
        for (int k = 0; k < 400 && consumed < pushed; k++) cycle();
        check("rand_consumed", 32'(consumed), 32'(pushed));

        // Unexpected read data with nothing in flight.
        do_reset();
        release_reset();
        repeat (3) cycle();
        chk = 1'b0;
        fifo_dout_valid = 1'b1;
        fifo_dout = DW'(18'h2abcd);
        cycle();
        check("err_set", 32'(err_unexp), 32'(1));
        repeat (5) cycle();
        check("err_sticky", 32'(err_unexp), 32'(1));
        rst_n = 1'b0;
        #1;
        check("err_cleared", 32'(err_unexp), 32'(0));
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
